// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS frequency-sweep sequencer
package dds_pkg;

    typedef enum logic [1:0] {
        SW_SINGLE = 2'd0,
        SW_SAW    = 2'd1,
        SW_TRI    = 2'd2
    } sweep_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // 1 MHz expressed as a tuning word for a 200 MHz DDS clock
    localparam logic [31:0] TW_1MHZ_AT_200MHZ = 32'h0147AE14;

    // Mode encoding 3 is reserved and behaves as a single sweep
    function automatic sweep_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SW_SAW;
            2'd2:    return SW_TRI;
            default: return SW_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - loadable dwell down-counter with expire flag
module sweep_dwell_timer #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [DW-1:0] dwell_i,
    output logic          expire_o
);

    logic [DW-1:0] count_q, count_d;

    // A dwell of 0 is held for one cycle, same as a dwell of 1
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = (dwell_i == '0) ? DW'(1) : dwell_i;
        end else if (count_q != '0) begin
            count_d = count_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == DW'(1));

endmodule

// File: rtl/dds_sweep_gen.sv
// rtl/dds_sweep_gen.sv - tuning-word sweep sequencer feeding dds_slave freq/synch
module dds_sweep_gen
    import dds_pkg::*;
#(
    parameter int FW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [1:0]    mode_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_step_i,
    input  logic [DW-1:0] dwell_i,
    output logic [FW-1:0] freq_o,
    output logic          synch_o,
    output logic          busy_o,
    output logic          done_o
);

    sweep_state_t  state_q;
    sweep_mode_t   mode_q;
    logic [FW-1:0] start_q, stop_q, step_q, freq_q;
    logic [DW-1:0] dwell_q;
    logic          dir_up_q;
    logic          synch_q, busy_q, done_q;

    logic          expire;
    logic          at_stop;
    logic          timer_load;
    logic [FW-1:0] step_next_d;
    logic [FW-1:0] tri_next_d;

    // Step one increment toward target in FW+1 bits so overshoot and
    // wrap past 0 / all-ones both clamp to the target instead of wrapping.
    function automatic logic [FW-1:0] step_toward(
        input logic [FW-1:0] cur,
        input logic [FW-1:0] step,
        input logic [FW-1:0] target,
        input logic          up
    );
        logic [FW:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, step};
            if (step == '0 || nxt > {1'b0, target}) nxt = {1'b0, target};
        end else begin
            nxt = {1'b0, cur} - {1'b0, step};
            if (step == '0 || nxt[FW] || nxt[FW-1:0] < target) nxt = {1'b0, target};
        end
        return nxt[FW-1:0];
    endfunction

    always_comb begin
        at_stop     = (freq_q == stop_q);
        step_next_d = step_toward(freq_q, step_q, stop_q, dir_up_q);
        tri_next_d  = step_toward(freq_q, step_q, start_q, !dir_up_q);
        timer_load  = 1'b0;
        if (!abort_i) begin
            if (state_q == ST_LOAD) begin
                timer_load = 1'b1;
            end else if (state_q == ST_DWELL && expire) begin
                timer_load = !(at_stop && mode_q == SW_SINGLE);
            end
        end
    end

    sweep_dwell_timer #(
        .DW(DW)
    ) u_dwell_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (abort_i),
        .load_i   (timer_load),
        .dwell_i  (dwell_q),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mode_q   <= SW_SINGLE;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            dir_up_q <= 1'b1;
            freq_q   <= '0;
            synch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            synch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    synch_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        mode_q   <= decode_mode(mode_i);
                        start_q  <= f_start_i;
                        stop_q   <= f_stop_i;
                        step_q   <= f_step_i;
                        dwell_q  <= dwell_i;
                        dir_up_q <= (f_stop_i >= f_start_i);
                        state_q  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    freq_q  <= start_q;
                    synch_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= ST_DWELL;
                end
                ST_DWELL: begin
                    synch_q <= 1'b0;
                    if (expire) begin
                        if (!at_stop) begin
                            freq_q  <= step_next_d;
                            synch_q <= 1'b1;
                        end else begin
                            case (mode_q)
                                SW_SAW: begin
                                    freq_q  <= start_q;
                                    synch_q <= 1'b1;
                                end
                                // Triangle turns around: endpoints swap, direction flips
                                SW_TRI: begin
                                    start_q  <= stop_q;
                                    stop_q   <= start_q;
                                    dir_up_q <= !dir_up_q;
                                    freq_q   <= tri_next_d;
                                    synch_q  <= 1'b1;
                                end
                                default: begin
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                    state_q <= ST_DONE;
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign freq_o  = freq_q;
    assign synch_o = synch_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb/tb_dds_sweep_gen.sv - directed self-checking bench for dds_sweep_gen
module tb_dds_sweep_gen;
    import dds_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [31:0] dwell;
    logic [31:0] freq;
    logic        synch;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_fail;
    int          test_id;
    bit          poke;
    logic [31:0] exp_w [0:15];

    dds_sweep_gen #(
        .FW(32),
        .DW(32)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .mode_i    (mode),
        .f_start_i (f_start),
        .f_stop_i  (f_stop),
        .f_step_i  (f_step),
        .dwell_i   (dwell),
        .freq_o    (freq),
        .synch_o   (synch),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL [t%0d] %s: got 0x%0h, expected 0x%0h", test_id, tag, obs, exp);
        end
    endtask

    // Starts a sweep and checks n words, each held hold cycles, against exp_w
    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                             input logic [31:0] dw, input logic [1:0] md, input int n,
                             input int hold, input bit exp_done);
        @(negedge clk);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("load_synch", synch, 0);
        check_eq("load_busy", busy, 0);
        if (poke) begin
            start = 1'b1; f_start = 32'h5555; f_stop = 32'h0; f_step = 32'h1; dwell = 32'd7;
        end
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_eq($sformatf("freq_w%0d_h%0d", k, h), freq, exp_w[k]);
                check_eq($sformatf("synch_w%0d_h%0d", k, h), synch, (h == 0) ? 1 : 0);
                check_eq($sformatf("busy_w%0d_h%0d", k, h), busy, 1);
                check_eq($sformatf("done_w%0d_h%0d", k, h), done, 0);
            end
        end
        start = 1'b0;
        if (exp_done) begin
            @(negedge clk);
            check_eq("done_pulse", done, 1);
            check_eq("done_busy", busy, 0);
            check_eq("done_synch", synch, 0);
            check_eq("done_freq", freq, exp_w[n-1]);
            @(negedge clk);
            check_eq("after_done", done, 0);
            check_eq("after_busy", busy, 0);
            check_eq("after_freq", freq, exp_w[n-1]);
        end
    endtask

    task automatic do_abort(input logic [31:0] frozen);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_synch", synch, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_freq", freq, frozen);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_synch", synch, 0);
            check_eq("idle_done", done, 0);
            check_eq("idle_freq", freq, frozen);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; test_id = 0; poke = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_freq", freq, 0);
        check_eq("rst_synch", synch, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;

        test_id = 1;
        exp_w[0] = 32'h0147AE14; exp_w[1] = 32'h028F5C28; exp_w[2] = 32'h03D70A3C;
        exp_w[3] = 32'h051EB850; exp_w[4] = 32'h06666664;
        run_sweep(TW_1MHZ_AT_200MHZ, 32'h06666664, TW_1MHZ_AT_200MHZ, 32'd4, 2'd0, 5, 4, 1'b1);

        test_id = 2;
        exp_w[0] = 32'h100; exp_w[1] = 32'h200; exp_w[2] = 32'h250;
        run_sweep(32'h100, 32'h250, 32'h100, 32'd2, 2'd0, 3, 2, 1'b1);

        test_id = 3;
        exp_w[0] = 32'h300; exp_w[1] = 32'h200; exp_w[2] = 32'h100;
        run_sweep(32'h300, 32'h100, 32'h100, 32'd3, 2'd3, 3, 3, 1'b1);

        test_id = 4;
        exp_w[0] = 32'h100; exp_w[1] = 32'h200; exp_w[2] = 32'h300; exp_w[3] = 32'h200;
        exp_w[4] = 32'h100; exp_w[5] = 32'h200; exp_w[6] = 32'h300;
        run_sweep(32'h100, 32'h300, 32'h100, 32'd1, 2'd2, 7, 1, 1'b0);
        do_abort(32'h300);

        test_id = 5;
        exp_w[0] = 32'hFFFFFF00; exp_w[1] = 32'hFFFFFF80; exp_w[2] = 32'hFFFFFFFF;
        run_sweep(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 32'd0, 2'd0, 3, 1, 1'b1);

        test_id = 6;
        exp_w[0] = 32'h10; exp_w[1] = 32'h20; exp_w[2] = 32'h30;
        exp_w[3] = 32'h10; exp_w[4] = 32'h20; exp_w[5] = 32'h30;
        run_sweep(32'h10, 32'h30, 32'h10, 32'd2, 2'd1, 6, 2, 1'b0);
        do_abort(32'h30);

        test_id = 7;
        @(negedge clk);
        f_start = 32'h1000; f_stop = 32'h5000; f_step = 32'h1000; dwell = 32'd3; mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_freq", freq, 0);
        check_eq("mid_rst_synch", synch, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_done", done, 0);

        test_id = 8;
        start = 1'b1; abort = 1'b1;
        f_start = 32'h400; f_stop = 32'h800; f_step = 32'h100; dwell = 32'd1; mode = 2'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("sa_busy", busy, 0);
            check_eq("sa_synch", synch, 0);
            check_eq("sa_freq", freq, 0);
            @(negedge clk);
        end

        test_id = 9;
        poke = 1'b1;
        exp_w[0] = 32'h100; exp_w[1] = 32'h200; exp_w[2] = 32'h250;
        run_sweep(32'h100, 32'h250, 32'h100, 32'd2, 2'd0, 3, 2, 1'b1);
        poke = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
